// File: rtl/mod_n_seq_ctrl.sv
// rtl/mod_n_seq_ctrl.sv - sequencer for a programmable modulus-M up-counter (optional pause: MOD_N_SEQ_CTRL_PAUSE_EN)
module mod_n_seq_ctrl #(
    parameter int WIDTH = 4,
    parameter int RW    = 8,
    parameter int DEF_N = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_mod,
    input  logic [RW-1:0]    cfg_reps,
`ifdef MOD_N_SEQ_CTRL_PAUSE_EN
    input  logic             pause,
`endif
    input  logic             start,
    input  logic             stop,
    output logic [WIDTH-1:0] count,
    output logic             tick,
    output logic [RW-1:0]    wraps,
    output logic             busy,
    output logic             done
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] DEF_MOD = WIDTH'(DEF_N);
    localparam logic [WIDTH-1:0] ONE_W   = WIDTH'(1);
    localparam logic [RW-1:0]    ONE_R   = RW'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] mod_q, mod_d;
    logic [RW-1:0]    reps_q, reps_d;
    logic [RW-1:0]    wraps_q, wraps_d;
    logic             tick_q, tick_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;

    logic             hold_w;
    logic [WIDTH-1:0] last_w;
    logic [RW-1:0]    wraps_inc_w;

`ifdef MOD_N_SEQ_CTRL_PAUSE_EN
    assign hold_w = pause;
`else
    assign hold_w = 1'b0;
`endif

    // mod_q - 1 wraps to all-ones when mod_q is 0, which is exactly the
    // last count of a full 2^WIDTH period, so one compare covers both cases.
    assign last_w      = mod_q - ONE_W;
    assign wraps_inc_w = wraps_q + ONE_R;

    // State, datapath and output registers; rst wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            mod_q   <= DEF_MOD;
            reps_q  <= '0;
            wraps_q <= '0;
            tick_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            mod_q   <= mod_d;
            reps_q  <= reps_d;
            wraps_q <= wraps_d;
            tick_q  <= tick_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state and datapath decode; tick/done are single-cycle pulses.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        mod_d   = mod_q;
        reps_d  = reps_q;
        wraps_d = wraps_q;
        tick_d  = 1'b0;
        done_d  = 1'b0;
        busy_d  = busy_q;
        unique case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                // Config lands on the same edge as start, so it governs the run.
                if (cfg_valid) begin
                    mod_d  = cfg_mod;
                    reps_d = cfg_reps;
                end
                if (start && !stop) begin
                    state_d = RUN;
                    count_d = '0;
                    wraps_d = '0;
                    busy_d  = 1'b1;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                    count_d = '0;
                    busy_d  = 1'b0;
                end else if (!hold_w) begin
                    if (count_q == last_w) begin
                        count_d = '0;
                        tick_d  = 1'b1;
                        wraps_d = wraps_inc_w;
                        if ((reps_q != '0) && (wraps_inc_w == reps_q)) begin
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                            state_d = IDLE;
                        end
                    end else begin
                        count_d = count_q + ONE_W;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign cfg_ready = (state_q == IDLE);
    assign count     = count_q;
    assign tick      = tick_q;
    assign wraps     = wraps_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_mod_n_seq_ctrl.sv
// tb/tb_mod_n_seq_ctrl.sv - self-checking bench for mod_n_seq_ctrl
module tb_mod_n_seq_ctrl;

    localparam int WIDTH = 4;
    localparam int RW    = 8;
    localparam int DEF_N = 10;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cfg_valid = 1'b0;
    logic             cfg_ready;
    logic [WIDTH-1:0] cfg_mod = '0;
    logic [RW-1:0]    cfg_reps = '0;
    logic             pause = 1'b0;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic [WIDTH-1:0] count;
    logic             tick;
    logic [RW-1:0]    wraps;
    logic             busy;
    logic             done;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    mod_n_seq_ctrl #(.WIDTH(WIDTH), .RW(RW), .DEF_N(DEF_N)) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_mod   (cfg_mod),
        .cfg_reps  (cfg_reps),
`ifdef MOD_N_SEQ_CTRL_PAUSE_EN
        .pause     (pause),
`endif
        .start     (start),
        .stop      (stop),
        .count     (count),
        .tick      (tick),
        .wraps     (wraps),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a run is just "i counting cycles since start";
    // every output follows from i, Meff and R by plain arithmetic.
    bit m_run = 1'b0;
    int m_i = 0, m_mod = DEF_N, m_reps = 0, m_meff;
    int e_count = 0, e_tick = 0, e_done = 0, e_busy = 0, e_wraps = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_run = 1'b0; m_mod = DEF_N; m_reps = 0;
            e_count = 0; e_tick = 0; e_done = 0; e_busy = 0; e_wraps = 0;
        end else if (!m_run) begin
            e_tick = 0; e_done = 0;
            if (cfg_valid) begin
                m_mod = int'(cfg_mod); m_reps = int'(cfg_reps);
            end
            if (start && !stop) begin
                m_run = 1'b1; m_i = 0;
                e_count = 0; e_wraps = 0; e_busy = 1;
            end
        end else if (stop) begin
            m_run = 1'b0; e_count = 0; e_busy = 0; e_tick = 0; e_done = 0;
        end else if (pause) begin
            e_tick = 0; e_done = 0;
        end else begin
            m_i++;
            m_meff  = (m_mod == 0) ? (1 << WIDTH) : m_mod;
            e_count = m_i % m_meff;
            e_tick  = (m_i % m_meff == 0) ? 1 : 0;
            e_wraps = (m_i / m_meff) % (1 << RW);
            e_done  = 0;
            if (m_reps != 0 && m_i / m_meff == m_reps) begin
                e_done = 1; e_busy = 0; m_run = 1'b0;
            end
        end
    end

    // Every-cycle comparison against the model, half a cycle after the edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cmp_count", int'(count), e_count);
            chk("cmp_tick", int'(tick), e_tick);
            chk("cmp_done", int'(done), e_done);
            chk("cmp_busy", int'(busy), e_busy);
            chk("cmp_wraps", int'(wraps), e_wraps);
            chk("cmp_ready", int'(cfg_ready), m_run ? 0 : 1);
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive config and start together for one cycle; returns just after t0.
    task automatic cfg_start(input int m, input int r);
        cfg_valid = 1'b1; cfg_mod = WIDTH'(m); cfg_reps = RW'(r); start = 1'b1;
        step(1);
        cfg_valid = 1'b0; start = 1'b0;
    endtask

    initial begin
        // Reset and default config.
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        chk_en = 1'b1;
        chk("rst_count", int'(count), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ready", int'(cfg_ready), 1);

        cfg_valid = 1'b1; cfg_mod = 4'd10; cfg_reps = 8'd2;
        step(1);
        cfg_valid = 1'b0; start = 1'b1;
        step(1);
        start = 1'b0;
        step(9);
        chk("r1_count9", int'(count), 9);
        step(1);
        chk("r1_tick10", int'(tick), 1);
        chk("r1_wraps10", int'(wraps), 1);
        step(10);
        chk("r1_done20", int'(done), 1);
        chk("r1_busy20", int'(busy), 0);
        chk("r1_wraps20", int'(wraps), 2);
        step(1);
        chk("r1_done21", int'(done), 0);
        chk("r1_hold21", int'(wraps), 2);

        // Meff = 1: a tick every cycle, done on the third.
        cfg_start(1, 3);
        step(1);
        chk("m1_tick1", int'(tick), 1);
        step(2);
        chk("m1_tick3", int'(tick), 1);
        chk("m1_done3", int'(done), 1);
        chk("m1_count3", int'(count), 0);

        // Modulus 0 means full 2^WIDTH period.
        cfg_start(0, 1);
        step(15);
        chk("m0_count15", int'(count), 15);
        step(1);
        chk("m0_done16", int'(done), 1);
        chk("m0_count16", int'(count), 0);

        // Stop in the completing cycle wins.
        cfg_start(5, 1);
        step(4);
        chk("stp_count4", int'(count), 4);
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        chk("stp_done", int'(done), 0);
        chk("stp_tick", int'(tick), 0);
        chk("stp_count", int'(count), 0);
        chk("stp_ready", int'(cfg_ready), 1);

        // start + stop together in IDLE stays IDLE.
        start = 1'b1; stop = 1'b1;
        step(1);
        start = 1'b0; stop = 1'b0;
        chk("ss_busy", int'(busy), 0);

        // Config held during RUN is refused and ignored.
        cfg_start(4, 1);
        cfg_valid = 1'b1; cfg_mod = 4'd9; cfg_reps = 8'd5;
        step(1);
        chk("crun_ready", int'(cfg_ready), 0);
        step(2);
        cfg_valid = 1'b0;
        step(1);
        chk("crun_done4", int'(done), 1);

        // Same-cycle config + start: the new modulus governs.
        cfg_start(3, 2);
        step(3);
        chk("sc_tick3", int'(tick), 1);
        chk("sc_wraps3", int'(wraps), 1);
        step(3);
        chk("sc_done6", int'(done), 1);

        // Continuous run with wrap counter rollover.
        cfg_start(2, 0);
        step(510);
        chk("cont_w255", int'(wraps), 255);
        step(2);
        chk("cont_w0", int'(wraps), 0);
        step(88);
        chk("cont_busy", int'(busy), 1);

        // Reset mid-run restores the default modulus.
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("mrst_busy", int'(busy), 0);
        chk("mrst_count", int'(count), 0);
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(9);
        chk("mrst_count9", int'(count), 9);
        step(1);
        chk("mrst_tick10", int'(tick), 1);
        stop = 1'b1;
        step(1);
        stop = 1'b0;

`ifdef MOD_N_SEQ_CTRL_PAUSE_EN
        // Pause holds the count and delays the first tick.
        cfg_start(4, 0);
        step(2);
        pause = 1'b1;
        step(3);
        chk("pz_hold", int'(count), 2);
        chk("pz_busy", int'(busy), 1);
        pause = 1'b0;
        step(1);
        chk("pz_tick6", int'(tick), 0);
        step(1);
        chk("pz_tick7", int'(tick), 1);
        stop = 1'b1;
        step(1);
        stop = 1'b0;
`endif

        // Randomized traffic checked by the model every cycle.
        for (int run = 0; run < 30; run++) begin
            for (int c = 0; c < 60; c++) begin
                rst       = ($urandom_range(0, 199) == 0);
                cfg_valid = ($urandom_range(0, 3) == 0);
                cfg_mod   = WIDTH'($urandom_range(0, 15));
                cfg_reps  = RW'($urandom_range(0, 4));
                start     = ($urandom_range(0, 3) == 0);
                stop      = ($urandom_range(0, 29) == 0);
`ifdef MOD_N_SEQ_CTRL_PAUSE_EN
                pause     = ($urandom_range(0, 4) == 0);
`endif
                step(1);
            end
        end
        rst = 1'b0; cfg_valid = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0;
        step(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
